// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes and fetch FSM state type for the CPU core.
package cpu_pkg;
  localparam int PC_W = 16;
  localparam int INSTR_W = 20;
  localparam logic [4:0] OPCODE_HALT = 5'b11111;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_perf_counters.sv
// fetch_perf_counters: wrapping instruction counter and saturating stall counter.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_inc,
  input  logic        stall_inc,
  output logic [15:0] instr_count,
  output logic [15:0] stall_count
);
  logic [15:0] instr_q, instr_d, stall_q, stall_d;
  always_comb begin
    instr_d = instr_inc ? instr_q + 16'd1 : instr_q;
    stall_d = (stall_inc && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      instr_q <= instr_d;
      stall_q <= stall_d;
    end
  assign instr_count = instr_q;
  assign stall_count = stall_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and BOOT/RUN/HALT control for a 1-cycle ROM.
module fetch_stage #(
  parameter int PC_W = 16,
  parameter int INSTR_W = 20,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               select_pc_mux,
  input  logic [PC_W-1:0]    branch_address,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc_fetch,
  output logic [INSTR_W-1:0] instruction_fetch,
  output logic               fetch_valid,
  output logic               halted,
  output logic [15:0]        instr_count,
  output logic [15:0]        stall_count
);
  import cpu_pkg::*;
  fetch_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic run, halt_detect;
  assign run = state_q == RUN;
  assign halt_detect = run && !stall && !select_pc_mux && imem_rdata[INSTR_W-1 -: 5] == OPCODE_HALT;
  // pc_d is the address issued to the ROM, so it becomes pc_q alongside its data
  always_comb begin
    pc_d = state_q == BOOT ? RESET_PC
         : (!run || halt_detect || stall) ? pc_q
         : select_pc_mux ? branch_address
         : pc_q + PC_W'(1);
    state_d = state_q == BOOT ? RUN : halt_detect ? HALT : state_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  assign imem_addr = !reset ? RESET_PC : pc_d;
  assign pc_fetch = pc_q;
  assign fetch_valid = run;
  assign halted = state_q == HALT;
  assign instruction_fetch = run ? imem_rdata : NOP_INSTR;
  fetch_perf_counters u_perf (
    .clk(clk),
    .reset(reset),
    .instr_inc(run && !stall),
    .stall_inc(run && stall),
    .instr_count(instr_count),
    .stall_count(stall_count)
  );
endmodule
